// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-stage constants and the queued entry type
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular queue (push/pop/flush, full/empty, zeroed head when empty)
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = empty ? '0 : mem[rd];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + AW'(do_pop);
      wr <= wr + AW'(do_push);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push & ~flush) mem[wr] <= din;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner, imem driver and buffered valid/ready fetch queue with redirect flush
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] PC_STEP = fetch_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetchEn,
  output logic [ADDR_W-1:0] imemAddr,
  output logic              imemReq,
  input  logic [DATA_W-1:0] imemData,
  output logic              instrValid,
  input  logic              instrReady,
  output logic [DATA_W-1:0] instrOut,
  output logic [ADDR_W-1:0] instrPc,
  output logic [ADDR_W-1:0] instrPcNext,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              misalignErr
);
  logic [ADDR_W-1:0] pc;
  fetch_entry_t head, din;
  logic full, empty, deq, push;
  assign instrValid = ~empty;
  assign deq = instrValid & instrReady;
  // rst_n gate keeps imemReq low while reset is held
  assign push = rst_n & fetchEn & ~redirectValid & (~full | deq);
  assign imemReq = push;
  assign imemAddr = pc;
  assign din = '{pc: pc, instr: imemData};
  assign instrOut = head.instr;
  assign instrPc = head.pc;
  assign instrPcNext = empty ? '0 : head.pc + PC_STEP;
  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(deq),
    .flush(redirectValid),
    .din(din),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      misalignErr <= 1'b0;
    end else if (redirectValid) begin
      pc <= {redirectPc[ADDR_W-1:2], 2'b00};
      misalignErr <= misalignErr | (redirectPc[1:0] != 2'b00);
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table vectors, queue scoreboard and async-reset sequence for instr_fetch_unit
module tb_instr_fetch_unit;
  logic clk = 0, rst_n = 0, fetchEn = 0, instrReady = 0, redirectValid = 0;
  logic [31:0] redirectPc = 0;
  logic [31:0] imemAddr, imemData, instrOut, instrPc, instrPcNext;
  logic imemReq, instrValid, misalignErr;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h11;
  endfunction
  assign imemData = mem_word(imemAddr);
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetchEn(fetchEn), .imemAddr(imemAddr), .imemReq(imemReq),
    .imemData(imemData), .instrValid(instrValid), .instrReady(instrReady), .instrOut(instrOut),
    .instrPc(instrPc), .instrPcNext(instrPcNext), .redirectValid(redirectValid),
    .redirectPc(redirectPc), .misalignErr(misalignErr)
  );
  task automatic chk(input string n, input logic [130:0] got, input logic [130:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h want %h", n, $time, got, exp);
    end
  endtask
  function automatic logic [130:0] dut_state();
    return {instrValid, imemReq, misalignErr, imemAddr, instrPc, instrOut, instrPcNext};
  endfunction
  typedef struct { logic [31:0] pc, instr; } ent_t;
  ent_t sb[$];
  ent_t h;
  logic [31:0] m_pc;
  logic m_err, ev, edeq, epush;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_pc = 0;
      m_err = 0;
    end else begin
      ev = sb.size() != 0;
      edeq = ev & instrReady;
      epush = fetchEn & ~redirectValid & ((sb.size() < 2) | edeq);
      h = '{0, 0};
      if (ev) h = sb[0];
      chk("sb", dut_state(), {ev, epush, m_err, m_pc, h.pc, h.instr, ev ? h.pc + 32'd4 : 32'd0});
      if (redirectValid) begin
        sb.delete();
        if (redirectPc[1:0] != 0) m_err = 1;
        m_pc = {redirectPc[31:2], 2'b00};
      end else begin
        if (edeq) void'(sb.pop_front());
        if (epush) begin
          sb.push_back('{m_pc, mem_word(m_pc)});
          m_pc += 4;
        end
      end
    end
  end
  typedef struct {
    bit rst, fe, rdy, rv;
    logic [31:0] rpc;
    bit v, req, err;
    logic [31:0] addr, pc, instr;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input bit rst, fe, rdy, rv, input logic [31:0] rpc, input bit v, req, err,
                     input logic [31:0] addr, pc, instr);
    tbl.push_back('{rst, fe, rdy, rv, rpc, v, req, err, addr, pc, instr});
  endtask
  initial begin
    add(1,0,0,0,0,         0,0,0, 32'h0,  32'h0,  32'h0);
    add(0,1,1,0,0,         0,1,0, 32'h0,  32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,0, 32'h4,  32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,0, 32'h8,  32'h4,  32'h11);
    add(0,1,1,0,0,         1,1,0, 32'hC,  32'h8,  32'h22);
    add(0,1,1,0,0,         1,1,0, 32'h10, 32'hC,  32'h33);
    add(1,0,0,0,0,         0,0,0, 32'h0,  32'h0,  32'h0);
    add(0,1,0,0,0,         0,1,0, 32'h0,  32'h0,  32'h0);
    add(0,1,0,0,0,         1,1,0, 32'h4,  32'h0,  32'h0);
    add(0,1,0,0,0,         1,0,0, 32'h8,  32'h0,  32'h0);
    add(0,1,0,0,0,         1,0,0, 32'h8,  32'h0,  32'h0);
    add(0,1,0,0,0,         1,0,0, 32'h8,  32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,0, 32'h8,  32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,0, 32'hC,  32'h4,  32'h11);
    add(0,1,1,0,0,         1,1,0, 32'h10, 32'h8,  32'h22);
    add(0,1,1,1,32'h40,    1,0,0, 32'h14, 32'hC,  32'h33);
    add(0,1,1,0,0,         0,1,0, 32'h40, 32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,0, 32'h44, 32'h40, 32'h110);
    add(0,1,1,0,0,         1,1,0, 32'h48, 32'h44, 32'h121);
    add(0,1,1,1,32'h42,    1,0,0, 32'h4C, 32'h48, 32'h132);
    add(0,1,1,0,0,         0,1,1, 32'h40, 32'h0,  32'h0);
    add(0,1,1,0,0,         1,1,1, 32'h44, 32'h40, 32'h110);
    add(0,1,1,1,32'hFFFFFFFC, 1,0,1, 32'h48, 32'h44, 32'h121);
    add(0,1,1,0,0,         0,1,1, 32'hFFFFFFFC, 32'h0, 32'h0);
    add(0,1,1,0,0,         1,1,1, 32'h0,  32'hFFFFFFFC, 32'h3FFFFFEF);
    add(0,1,1,0,0,         1,1,1, 32'h4,  32'h0,  32'h0);
    add(0,0,0,0,0,         1,0,1, 32'h8,  32'h4,  32'h11);
    add(0,0,1,0,0,         1,0,1, 32'h8,  32'h4,  32'h11);
    add(0,0,1,0,0,         0,0,1, 32'h8,  32'h0,  32'h0);
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n = !tbl[i].rst;
      fetchEn = tbl[i].fe;
      instrReady = tbl[i].rdy;
      redirectValid = tbl[i].rv;
      redirectPc = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_state(),
          {tbl[i].v, tbl[i].req, tbl[i].err, tbl[i].addr, tbl[i].pc, tbl[i].instr,
           tbl[i].v ? tbl[i].pc + 32'd4 : 32'd0});
    end
    repeat (300) begin
      @(posedge clk);
      #1;
      fetchEn = $urandom_range(0, 3) != 0;
      instrReady = $urandom_range(0, 2) != 0;
      redirectValid = $urandom_range(0, 15) == 0;
      redirectPc = 32'($urandom_range(0, 1023));
    end
    @(posedge clk);
    #1;
    fetchEn = 1;
    instrReady = 1;
    redirectValid = 0;
    repeat (3) @(posedge clk);
    chk("pre_rst_valid", {130'd0, instrValid}, 131'd1);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst", {128'd0, instrValid, misalignErr, imemReq}, 131'd0);
    chk("async_rst_pc", {99'd0, imemAddr}, 131'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_rel", {98'd0, instrValid, imemAddr}, 131'd0);
    @(negedge clk);
    chk("rst_first", {98'd0, instrValid, instrPc}, {98'd0, 1'b1, 32'h0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
